page_drain: RTL and testbench
=============================

Name: page_drain

Overview:
- Read-side controller for the paged block memory.
- The write side fills a page and signals it ready. This block then:
  - samples the page's entry count from the memory's count output;
  - issues reads of addresses 0..nent-1 of that page, honouring the memory's fixed read latency;
  - presents the entries on a valid/ready stream;
  - pulses page_done so the writer can reuse the page.
- Sits between the paged memory read port and downstream packet logic.

Parameters:
- RAM_WIDTH, 18, data word width; must match the memory.
- RAM_DEPTH, 1024, entries per page; address width is ceil(log2(RAM_DEPTH)).
- PAGE_BITS, 1, page-select width; number of pages is 2**PAGE_BITS.
- RD_LATENCY, 2, memory read latency in cycles: 2 = output-register mode, 1 = low-latency mode.

Ports:
- clk  in  1  single clock, also drives the memory read clock.
- rst_n  in  1  asynchronous active-low reset.
- page_ready  in  1  one-cycle pulse: page page_ready_idx has been filled.
- page_ready_idx  in  PAGE_BITS  page index qualified by page_ready.
- page_done  out  1  one-cycle pulse: page page_done_idx has been fully drained.
- page_done_idx  out  PAGE_BITS  index of the drained page.
- rd_en  out  1  memory read enable.
- rd_addr  out  ceil(log2(RAM_DEPTH))  memory read address.
- rd_page  out  PAGE_BITS  memory read page.
- rd_regce  out  1  memory output-register enable; tied to 1.
- rd_rst  out  1  memory output-register reset; tied to 0.
- rd_nent  in  5  entry count of rd_page; valid the cycle after an rd_en cycle.
- rd_data  in  RAM_WIDTH  memory read data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  RAM_WIDTH  stream data.
- m_last  out  1  marks the final beat of a page.
- m_page  out  PAGE_BITS  page the current beat belongs to.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, pending mask 0, FIFO empty, in-flight pipe 0, all outputs 0 except rd_regce=1; the round-robin pointer resets to page 0. Reset mid-drain discards all pending, in-flight and buffered beats; no page_done is emitted.
- Pending mask: page_ready sets bit[page_ready_idx]. A page is cleared from the mask on entry to LATCH. A page_ready for a page already pending has no effect. A page_ready for the page currently draining re-sets its bit, so that page is drained again afterwards.
- FSM:
  - IDLE: if the pending mask is nonzero, select the first set bit at or after the round-robin pointer -> LATCH.
  - LATCH (1 cycle): rd_en=1, rd_page=selected page, rd_addr=0. This read is a dummy and is not tagged valid -> COUNT.
  - COUNT (1 cycle): register cnt = min(rd_nent, RAM_DEPTH). If cnt==0 -> DONE, else -> ISSUE with addr=0.
  - ISSUE:
    - Issue condition: FIFO occupancy + in-flight reads < FIFO_DEPTH, where FIFO_DEPTH = RD_LATENCY+2.
    - When the condition holds: rd_en=1, rd_addr=addr, and a tagged-valid token enters a RD_LATENCY-deep shift pipe; the final read's token carries last=1.
    - After issuing addr==cnt-1 -> DRAIN.
    - When the condition fails, rd_en=0 and address/page are held.
  - DRAIN: wait until the pipe and FIFO are empty and the last beat has been accepted -> DONE.
  - DONE (1 cycle): page_done=1, page_done_idx=page, round-robin pointer = page+1 (mod pages) -> IDLE.
- Data capture: when a valid token exits the pipe, rd_data, its last flag and page are pushed into the FIFO. The credit check makes overflow impossible; overflow is a verification assertion.
- Stream:
  - m_valid = FIFO not empty; m_data/m_last/m_page come from the FIFO head.
  - These must stay stable while m_valid && !m_ready.
  - A beat transfers on m_valid && m_ready. Push and pop may occur in the same cycle.
- Throughput: one beat per cycle with m_ready held high. Per-page overhead is the LATCH, COUNT and DONE cycles plus RD_LATENCY.
- rd_page holds the selected page from LATCH through DRAIN.

Optional Feature:
- Macro PAGE_DRAIN_HEADER_EN.
- When defined, each page drain begins with one header beat pushed into the FIFO in COUNT:
  - m_data = {zero pad, page, cnt[4:0]};
  - m_last=0, or 1 if cnt==0.
  - Empty pages therefore still produce one beat.
  - The header consumes one FIFO credit; COUNT stalls until a slot is free.
- When undefined, there is no header and empty pages produce no stream beats; page_done is still pulsed.

Test Plan:
- Page 0 filled with nent=5, data 0x10..0x14; page_ready idx 0; m_ready=1 -> 5 beats 0x10..0x14 on consecutive cycles, m_last on 0x14, page_done idx 0 one cycle after the last beat is accepted.
- Same stimulus with m_ready toggling 1,0,0,1 -> identical data order, m_data stable during stalls, rd_en never issues beyond the FIFO credit.
- Pages 0 and 1 made ready in the same cycle -> page 0 drained fully before page 1; then ready page 0 again -> served only after page 1 (round-robin).
- Page with nent=0 -> no beats and page_done pulsed; with PAGE_DRAIN_HEADER_EN, exactly one header beat with m_last=1.
- rst_n asserted mid-ISSUE of a nent=20 page -> m_valid=0, busy=0 and page_done=0 immediately; after reset release, a fresh page_ready drains all 20 entries.
- RD_LATENCY=1 with nent=31 -> 31 beats, data order correct, last beat at address 30.

Source files
------------

// File: rtl/page_drain.sv
// page_drain: read-side controller for a paged block memory. Waits for
// filled pages, reads their entry count, streams the entries out on a
// valid/ready port and pulses page_done when each page is fully drained.
// Ports: clk, rst_n (async, active low); page_ready/page_ready_idx in;
// page_done/page_done_idx out; rd_en/rd_addr/rd_page/rd_regce/rd_rst to
// the memory, rd_nent/rd_data from it; m_valid/m_ready/m_data/m_last/
// m_page stream; busy high outside IDLE.
// Optional macro PAGE_DRAIN_HEADER_EN: prefix every page with a header beat.
module page_drain #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int PAGE_BITS  = 1,
    parameter int RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         page_ready,
    input  logic [PAGE_BITS-1:0]         page_ready_idx,
    output logic                         page_done,
    output logic [PAGE_BITS-1:0]         page_done_idx,
    output logic                         rd_en,
    output logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
    output logic [PAGE_BITS-1:0]         rd_page,
    output logic                         rd_regce,
    output logic                         rd_rst,
    input  logic [4:0]                   rd_nent,
    input  logic [RAM_WIDTH-1:0]         rd_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [RAM_WIDTH-1:0]         m_data,
    output logic                         m_last,
    output logic [PAGE_BITS-1:0]         m_page,
    output logic                         busy
);

    localparam int AW  = $clog2(RAM_DEPTH);
    localparam int NP  = 2 ** PAGE_BITS;
    localparam int FD  = RD_LATENCY + 2;
    localparam int PW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int CTW = $clog2(FD + 1);
    localparam int CW  = (AW + 1 > 5) ? AW + 1 : 5;

    typedef enum logic [2:0] {
        IDLE, LATCH, COUNT, ISSUE, DRAIN, DONE
    } state_t;

    state_t state, state_n;

    logic [NP-1:0]        pend, pend_n;
    logic [PAGE_BITS-1:0] rr, page, sel, idx;
    logic                 sel_vld;
    logic [AW-1:0]        addr;
    logic [CW-1:0]        cnt, cnt_src, nent_min;
    logic [RD_LATENCY-1:0] pv, pl;
    logic [CTW-1:0]       inflight, occ;
    logic                 credit, issue, last_rd;
    logic                 hdr_push, push, pop;

    logic [RAM_WIDTH-1:0] f_data [FD];
    logic                 f_last [FD];
    logic [PAGE_BITS-1:0] f_page [FD];
    logic [PW-1:0]        wp, rp;
    logic [RAM_WIDTH-1:0] din;
    logic                 dl;

    // First pending page at or after the round-robin pointer.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NP; i++) begin
            idx = rr + PAGE_BITS'(i);
            if (!sel_vld && pend[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + CTW'(pv[i]);
    end

    // Every issued read already owns a FIFO slot, so pushes never overflow.
    assign credit  = (int'(occ) + int'(inflight)) < FD;
    assign last_rd = int'(addr) == int'(cnt) - 1;

    always_comb begin
        if (int'(rd_nent) > RAM_DEPTH)
            nent_min = CW'(RAM_DEPTH);
        else
            nent_min = CW'(rd_nent);
    end

`ifdef PAGE_DRAIN_HEADER_EN
    // rd_nent is only valid in the first COUNT cycle; keep it across stalls.
    logic cnt_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_hold <= 1'b0;
        else if (state == LATCH)
            cnt_hold <= 1'b0;
        else if (state == COUNT)
            cnt_hold <= 1'b1;
    end

    assign cnt_src = cnt_hold ? cnt : nent_min;
`else
    assign cnt_src = nent_min;
`endif

    always_comb begin
        state_n  = state;
        rd_en    = 1'b0;
        issue    = 1'b0;
        hdr_push = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_vld)
                    state_n = LATCH;
            end
            LATCH: begin
                rd_en   = 1'b1;
                state_n = COUNT;
            end
            COUNT: begin
`ifdef PAGE_DRAIN_HEADER_EN
                if (credit) begin
                    hdr_push = 1'b1;
                    state_n  = (cnt_src == '0) ? DONE : ISSUE;
                end
`else
                state_n = (cnt_src == '0) ? DONE : ISSUE;
`endif
            end
            ISSUE: begin
                if (credit) begin
                    rd_en = 1'b1;
                    issue = 1'b1;
                    if (last_rd)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final beat is accepted so page_done follows it.
                if (inflight == '0 &&
                    (occ == '0 || (occ == CTW'(1) && pop)))
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A re-ready of the page being drained wins over its clear.
    always_comb begin
        pend_n = pend;
        if (state == IDLE && sel_vld)
            pend_n[sel] = 1'b0;
        if (page_ready)
            pend_n[page_ready_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            rr    <= '0;
            page  <= '0;
            addr  <= '0;
            cnt   <= '0;
            pv    <= '0;
            pl    <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            unique case (state)
                IDLE: begin
                    if (sel_vld) begin
                        page <= sel;
                        addr <= '0;
                    end
                end
                COUNT: begin
                    cnt  <= cnt_src;
                    addr <= '0;
                end
                ISSUE: begin
                    if (issue && !last_rd)
                        addr <= addr + 1'b1;
                end
                DONE: begin
                    rr <= page + 1'b1;
                end
                default: ;
            endcase
            pv[0] <= issue;
            pl[0] <= issue && last_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pl[i] <= pl[i-1];
            end
        end
    end

    assign push = hdr_push | pv[RD_LATENCY-1];
    assign pop  = m_valid & m_ready;

    always_comb begin
        din = rd_data;
        dl  = pl[RD_LATENCY-1];
        if (hdr_push) begin
            din = RAM_WIDTH'({page, cnt_src[4:0]});
            dl  = (cnt_src == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
            for (int i = 0; i < FD; i++) begin
                f_data[i] <= '0;
                f_last[i] <= 1'b0;
                f_page[i] <= '0;
            end
        end else begin
            if (push) begin
                f_data[wp] <= din;
                f_last[wp] <= dl;
                f_page[wp] <= page;
                wp <= (wp == PW'(FD - 1)) ? '0 : wp + 1'b1;
            end
            if (pop)
                rp <= (rp == PW'(FD - 1)) ? '0 : rp + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && int'(occ) == FD));
    a_one_push: assert property (@(posedge clk) disable iff (!rst_n)
        !(hdr_push && pv[RD_LATENCY-1]));

    assign m_valid       = (occ != '0);
    assign m_data        = m_valid ? f_data[rp] : '0;
    assign m_last        = m_valid ? f_last[rp] : 1'b0;
    assign m_page        = m_valid ? f_page[rp] : '0;
    assign rd_addr       = addr;
    assign rd_page       = page;
    assign rd_regce      = 1'b1;
    assign rd_rst        = 1'b0;
    assign page_done     = (state == DONE);
    assign page_done_idx = page_done ? page : '0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_page_drain.sv
// tb_page_drain: exercises page_drain with RD_LATENCY 2 and 1 side by side,
// each against its own memory model, checked against an expected beat list.
module tb_page_drain;

    localparam int W = 18;
`ifdef PAGE_DRAIN_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic         p;
        logic         h;
    } beat_t;

    typedef struct packed {
        logic p;
        logic ne;
    } done_t;

    typedef struct {
        logic [1:0] mask;
        logic [4:0] n0;
        logic [4:0] n1;
        int         rmode;
        int         beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic page_ready = 1'b0;
    logic page_ready_idx = 1'b0;
    logic m_ready = 1'b0;

    logic pd0, pdi0, re0, rce0, rrs0, mv0, ml0, mp0, bsy0, rp0;
    logic pd1, pdi1, re1, rce1, rrs1, mv1, ml1, mp1, bsy1, rp1;
    logic [9:0] ra0, ra1;
    logic [4:0] nent0 = '0, nent1 = '0;
    logic [W-1:0] rdat0, rdat1, md0, md1;
    logic [W-1:0] m0_d1 = '0, m0_d2 = '0, m1_d1 = '0;

    logic [W-1:0] mdat [2][32];
    logic [4:0]   mnent [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rmode = 0;
    int ph = 0;
    int mrr = 0;
    bit run_mon = 0;

    beat_t qb0[$], qb1[$];
    done_t qd0[$], qd1[$];

    bit         stall_v [2];
    logic [W-1:0] stall_d [2];
    logic       stall_l [2], stall_p [2];
    bit         exp_latch [2];
    int         issued [2], popped [2], nbeats [2];
    bit         have_prev [2], prev_l [2], prev_h [2];
    int         prev_cyc [2], last_cyc [2];
    int         fdep [2];

    vec_t vt [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    page_drain #(.RD_LATENCY(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .page_ready(page_ready), .page_ready_idx(page_ready_idx),
        .page_done(pd0), .page_done_idx(pdi0),
        .rd_en(re0), .rd_addr(ra0), .rd_page(rp0),
        .rd_regce(rce0), .rd_rst(rrs0),
        .rd_nent(nent0), .rd_data(rdat0),
        .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
        .m_last(ml0), .m_page(mp0), .busy(bsy0)
    );

    page_drain #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .page_ready(page_ready), .page_ready_idx(page_ready_idx),
        .page_done(pd1), .page_done_idx(pdi1),
        .rd_en(re1), .rd_addr(ra1), .rd_page(rp1),
        .rd_regce(rce1), .rd_rst(rrs1),
        .rd_nent(nent1), .rd_data(rdat1),
        .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .m_last(ml1), .m_page(mp1), .busy(bsy1)
    );

    // Memory with output register (latency 2) and without (latency 1).
    always @(posedge clk) begin
        if (re0) begin
            nent0 <= mnent[rp0];
            m0_d1 <= mdat[rp0][ra0[4:0]];
        end
        m0_d2 <= m0_d1;
        if (re1) begin
            nent1 <= mnent[rp1];
            m1_d1 <= mdat[rp1][ra1[4:0]];
        end
    end
    assign rdat0 = m0_d2;
    assign rdat1 = m1_d1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input bit ok, input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic mv, input logic mr,
                       input logic [W-1:0] md, input logic ml,
                       input logic mp, input logic pd, input logic pdi,
                       input logic re);
        beat_t e;
        done_t dn;
        bit got;
        if (stall_v[k])
            chk(mv && md == stall_d[k] && ml == stall_l[k] &&
                mp == stall_p[k], "stable", k, md, stall_d[k]);
        stall_v[k] = mv && !mr;
        stall_d[k] = md;
        stall_l[k] = ml;
        stall_p[k] = mp;
        if (re) begin
            if (exp_latch[k]) begin
                exp_latch[k] = 0;
            end else begin
                issued[k]++;
                chk(issued[k] - popped[k] <= fdep[k], "credit", k,
                    issued[k] - popped[k], fdep[k]);
            end
        end
        if (mv && mr) begin
            popped[k]++;
            nbeats[k]++;
            got = 0;
            if (k == 0 && qb0.size() > 0) begin
                e = qb0.pop_front();
                got = 1;
            end else if (k == 1 && qb1.size() > 0) begin
                e = qb1.pop_front();
                got = 1;
            end
            chk(got, "beat_expected", k, md, 0);
            if (got) begin
                chk(md == e.d, "data", k, md, e.d);
                chk(ml == e.l, "last", k, ml, e.l);
                chk(mp == e.p, "page", k, mp, e.p);
                if (rmode == 0 && have_prev[k] && !prev_l[k] &&
                    !prev_h[k] && !e.h)
                    chk(cyc == prev_cyc[k] + 1, "b2b", k,
                        cyc - prev_cyc[k], 1);
                have_prev[k] = 1;
                prev_l[k] = e.l;
                prev_h[k] = e.h;
                prev_cyc[k] = cyc;
                if (e.l)
                    last_cyc[k] = cyc;
            end
        end
        if (pd) begin
            exp_latch[k] = 1;
            got = 0;
            if (k == 0 && qd0.size() > 0) begin
                dn = qd0.pop_front();
                got = 1;
            end else if (k == 1 && qd1.size() > 0) begin
                dn = qd1.pop_front();
                got = 1;
            end
            chk(got, "done_expected", k, pdi, 0);
            if (got) begin
                chk(pdi == dn.p, "done_idx", k, pdi, dn.p);
                if (dn.ne)
                    chk(cyc == last_cyc[k] + 1, "done_lat", k,
                        cyc - last_cyc[k], 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && run_mon) begin
            mon(0, mv0, m_ready, md0, ml0, mp0, pd0, pdi0, re0);
            mon(1, mv1, m_ready, md1, ml1, mp1, pd1, pdi1, re1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tb;
        qb0.delete();
        qb1.delete();
        qd0.delete();
        qd1.delete();
        for (int k = 0; k < 2; k++) begin
            stall_v[k] = 0;
            exp_latch[k] = 1;
            issued[k] = 0;
            popped[k] = 0;
            have_prev[k] = 0;
            prev_l[k] = 1;
            prev_h[k] = 0;
        end
    endtask

    task automatic expect_page(input int p);
        beat_t b;
        done_t dn;
        int n;
        n = int'(mnent[p]);
        if (HDR != 0) begin
            b.d = W'(p * 32 + n);
            b.l = (n == 0);
            b.p = p[0];
            b.h = 1'b1;
            qb0.push_back(b);
            qb1.push_back(b);
        end
        for (int a = 0; a < n; a++) begin
            b.d = mdat[p][a];
            b.l = (a == n - 1);
            b.p = p[0];
            b.h = 1'b0;
            qb0.push_back(b);
            qb1.push_back(b);
        end
        dn.p = p[0];
        dn.ne = (n != 0);
        qd0.push_back(dn);
        qd1.push_back(dn);
    endtask

    task automatic fire(input int p);
        page_ready = 1'b1;
        page_ready_idx = p[0];
        tick();
        page_ready = 1'b0;
    endtask

    // Pages are served round-robin from the model pointer; firing them in
    // that order keeps the arbitration independent of exact timing.
    task automatic serve(input logic [1:0] mask, output int nb);
        int st, p, lastp;
        st = mrr;
        lastp = mrr;
        nb = 0;
        for (int i = 0; i < 2; i++) begin
            p = (st + i) % 2;
            if (mask[p]) begin
                expect_page(p);
                nb += int'(mnent[p]) + HDR;
                lastp = p;
            end
        end
        for (int i = 0; i < 2; i++) begin
            p = (st + i) % 2;
            if (mask[p])
                fire(p);
        end
        if (mask != 2'b00)
            mrr = (lastp + 1) % 2;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (n < 4000 && !(!bsy0 && !bsy1 && !mv0 && !mv1 &&
               qb0.size() == 0 && qb1.size() == 0 &&
               qd0.size() == 0 && qd1.size() == 0)) begin
            tick();
            n++;
        end
        chk(n < 4000, nm, 0, n, 4000);
    endtask

    initial begin
        int s0, s1, nb, n;
        logic [1:0] mask;

        vt[0] = '{2'b01, 5'd5,  5'd0,  0, 5};
        vt[1] = '{2'b01, 5'd5,  5'd0,  1, 5};
        vt[2] = '{2'b11, 5'd3,  5'd4,  0, 7};
        vt[3] = '{2'b01, 5'd0,  5'd0,  0, 0};
        vt[4] = '{2'b10, 5'd0,  5'd31, 0, 31};
        vt[5] = '{2'b11, 5'd31, 5'd0,  2, 31};
        vt[6] = '{2'b11, 5'd0,  5'd0,  2, 0};
        vt[7] = '{2'b10, 5'd7,  5'd9,  1, 9};

        fdep[0] = 4;
        fdep[1] = 3;
        for (int p = 0; p < 2; p++) begin
            mnent[p] = '0;
            for (int a = 0; a < 32; a++)
                mdat[p][a] = '0;
        end
        clear_tb();
        nbeats[0] = 0;
        nbeats[1] = 0;

        repeat (3) tick();
        chk(rce0 == 1'b1, "rst_regce", 0, rce0, 1);
        chk(rrs0 == 1'b0, "rst_rdrst", 0, rrs0, 0);
        chk(mv0 == 1'b0, "rst_valid", 0, mv0, 0);
        chk(bsy0 == 1'b0, "rst_busy", 0, bsy0, 0);
        chk(pd0 == 1'b0, "rst_done", 0, pd0, 0);
        chk(re0 == 1'b0, "rst_rden", 0, re0, 0);
        chk(ra0 == 10'd0, "rst_addr", 0, ra0, 0);
        chk(mv1 == 1'b0 && bsy1 == 1'b0, "rst_idle", 1, mv1, 0);
        rst_n = 1'b1;
        run_mon = 1;
        tick();

        for (int r = 0; r < 8; r++) begin
            rmode = vt[r].rmode;
            mnent[0] = vt[r].n0;
            mnent[1] = vt[r].n1;
            for (int a = 0; a < 32; a++) begin
                mdat[0][a] = (r < 2) ? W'(32'h10 + a) : W'($urandom);
                mdat[1][a] = W'($urandom);
            end
            s0 = nbeats[0];
            s1 = nbeats[1];
            serve(vt[r].mask, nb);
            wait_idle("idle_timeout_vec");
            n = vt[r].beats + HDR * $countones(vt[r].mask);
            chk(nbeats[0] - s0 == n, "vec_beats", 0, nbeats[0] - s0, n);
            chk(nbeats[1] - s1 == n, "vec_beats", 1, nbeats[1] - s1, n);
        end

        // Page 0 re-readied while draining: page 1 must be served first.
        rmode = 0;
        mnent[0] = 5'd10;
        mnent[1] = 5'd6;
        for (int a = 0; a < 32; a++) begin
            mdat[0][a] = W'(32'h300 + a);
            mdat[1][a] = W'(32'h500 + a);
        end
        expect_page(0);
        expect_page(1);
        expect_page(0);
        fire(0);
        fire(1);
        repeat (6) tick();
        fire(0);
        mrr = 1;
        wait_idle("idle_timeout_rr");

        // Reset in the middle of a 20-entry page.
        mnent[0] = 5'd20;
        for (int a = 0; a < 32; a++)
            mdat[0][a] = W'($urandom);
        expect_page(0);
        s0 = nbeats[0];
        fire(0);
        n = 0;
        while (n < 300 && nbeats[0] - s0 < 3) begin
            tick();
            n++;
        end
        chk(n < 300, "rst_wait_timeout", 0, n, 300);
        rst_n = 1'b0;
        #1;
        chk(mv0 == 1'b0, "midrst_valid", 0, mv0, 0);
        chk(bsy0 == 1'b0, "midrst_busy", 0, bsy0, 0);
        chk(pd0 == 1'b0, "midrst_done", 0, pd0, 0);
        chk(mv1 == 1'b0, "midrst_valid", 1, mv1, 0);
        chk(bsy1 == 1'b0, "midrst_busy", 1, bsy1, 0);
        chk(pd1 == 1'b0, "midrst_done", 1, pd1, 0);
        clear_tb();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mrr = 0;
        s0 = nbeats[0];
        s1 = nbeats[1];
        serve(2'b01, nb);
        wait_idle("idle_timeout_rst");
        chk(nbeats[0] - s0 == 20 + HDR, "rst_beats", 0, nbeats[0] - s0, 20 + HDR);
        chk(nbeats[1] - s1 == 20 + HDR, "rst_beats", 1, nbeats[1] - s1, 20 + HDR);

        // Random pages and random back-pressure.
        for (int it = 0; it < 10; it++) begin
            rmode = 2;
            mask = 2'($urandom_range(1, 3));
            mnent[0] = 5'($urandom_range(0, 31));
            mnent[1] = 5'($urandom_range(0, 31));
            for (int a = 0; a < 32; a++) begin
                mdat[0][a] = W'($urandom);
                mdat[1][a] = W'($urandom);
            end
            s0 = nbeats[0];
            s1 = nbeats[1];
            serve(mask, nb);
            wait_idle("idle_timeout_rand");
            chk(nbeats[0] - s0 == nb, "rand_beats", 0, nbeats[0] - s0, nb);
            chk(nbeats[1] - s1 == nb, "rand_beats", 1, nbeats[1] - s1, nb);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
